// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between two level-request ports
// and schedules periodic auto-refresh.
//
// Each granted transaction is latched, then the arbiter drives the
// controller's request/flag handshake to completion. Read data is returned on
// the port's data_out register, together with a one-cycle ack.
//
// Ports:
//   sdram_clock, sdram_reset       clock and synchronous active-high reset
//   a_* / b_*                      port A (CPU) / port B (DMA) request
//                                  interfaces; requests are held until ack
//   access_address/num/data_in     transaction fields sent to the controller
//   write_request, read_request    request strobes, held until the flag is seen
//   enable_refresh                 one-cycle refresh trigger
//   write_flag, read_flag, idle,   controller status inputs
//   refresh_mode, access_data_out
module sdram_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 780
) (
  input  logic        sdram_clock,
  input  logic        sdram_reset,
  input  logic        a_read,
  input  logic        a_write,
  input  logic [24:0] a_address,
  input  logic [15:0] a_data_in,
  output logic [15:0] a_data_out,
  output logic        a_ack,
  input  logic        b_read,
  input  logic        b_write,
  input  logic [24:0] b_address,
  input  logic [15:0] b_data_in,
  output logic [15:0] b_data_out,
  output logic        b_ack,
  output logic [24:0] access_address,
  output logic [9:0]  access_num,
  output logic [15:0] access_data_in,
  output logic        write_request,
  output logic        read_request,
  output logic        enable_refresh,
  input  logic        write_flag,
  input  logic        read_flag,
  input  logic        idle,
  input  logic        refresh_mode,
  input  logic [15:0] access_data_out
);

  localparam int unsigned CountWidth = $clog2(REFRESH_INTERVAL + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StActive,
    StDone,
    StRefresh,
    StRefreshWait
  } state_e;

  state_e state_q, state_d;

  logic [CountWidth-1:0] refresh_count_q;
  logic                  refresh_seen_q;   // refresh_mode observed during this refresh
  logic                  last_grant_b_q;   // 1: port B was granted last
  logic                  mask_a_q, mask_b_q;
  logic                  grant_b_q;        // port owning the current transaction
  logic                  dir_write_q;

  logic req_a, req_b, pick_b, win_write;
  logic refresh_due, flag_match, start_issue, enter_refresh, capture;
  logic issue_write;
  logic write_request_d, read_request_d, enable_refresh_d, a_ack_d, b_ack_d;

  assign access_num = 10'h001;

  // Arbitration: the port just acked is masked for one IDLE cycle so a
  // requester can drop its level request after ack without a re-grant.
  always_comb begin
    req_a     = (a_read | a_write) & ~mask_a_q;
    req_b     = (b_read | b_write) & ~mask_b_q;
    pick_b    = req_b & (~req_a | ~last_grant_b_q);
    win_write = pick_b ? b_write : a_write;
  end

  assign refresh_due = (refresh_count_q == CountWidth'(REFRESH_INTERVAL));
  assign flag_match  = dir_write_q ? write_flag : read_flag;

  // State register
  always_ff @(posedge sdram_clock) begin
    if (sdram_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (idle) begin
          if (refresh_due) begin
            state_d = StRefresh;
          end else if (req_a | req_b) begin
            state_d = StIssue;
          end
        end
      end
      StIssue:       if (flag_match) state_d = StActive;
      StActive:      if (!flag_match) state_d = StDone;
      StDone:        state_d = StIdle;
      StRefresh:     state_d = StRefreshWait;
      StRefreshWait: if (refresh_seen_q && idle) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  assign start_issue   = (state_q == StIdle) && (state_d == StIssue);
  assign enter_refresh = (state_q == StIdle) && (state_d == StRefresh);
  assign capture       = ((state_q == StIssue) || (state_q == StActive)) &&
                         !dir_write_q && read_flag;

  // Output logic: next values of the registered outputs, decoded from state_d
  always_comb begin
    write_request_d  = 1'b0;
    read_request_d   = 1'b0;
    issue_write      = start_issue ? win_write : dir_write_q;
    if (state_d == StIssue) begin
      write_request_d = issue_write;
      read_request_d  = ~issue_write;
    end
    enable_refresh_d = (state_d == StRefresh);
    a_ack_d          = (state_d == StDone) && !grant_b_q;
    b_ack_d          = (state_d == StDone) && grant_b_q;
  end

  // Registered outputs and datapath
  always_ff @(posedge sdram_clock) begin
    if (sdram_reset) begin
      write_request   <= 1'b0;
      read_request    <= 1'b0;
      enable_refresh  <= 1'b0;
      a_ack           <= 1'b0;
      b_ack           <= 1'b0;
      access_address  <= '0;
      access_data_in  <= '0;
      a_data_out      <= '0;
      b_data_out      <= '0;
      refresh_count_q <= '0;
      refresh_seen_q  <= 1'b0;
      last_grant_b_q  <= 1'b1;
      mask_a_q        <= 1'b0;
      mask_b_q        <= 1'b0;
      grant_b_q       <= 1'b0;
      dir_write_q     <= 1'b0;
    end else begin
      write_request  <= write_request_d;
      read_request   <= read_request_d;
      enable_refresh <= enable_refresh_d;
      a_ack          <= a_ack_d;
      b_ack          <= b_ack_d;

      if (enter_refresh) begin
        refresh_count_q <= '0;
      end else if (!refresh_due) begin
        refresh_count_q <= refresh_count_q + 1'b1;
      end

      if (state_q == StRefresh) begin
        refresh_seen_q <= 1'b0;
      end else if ((state_q == StRefreshWait) && refresh_mode) begin
        refresh_seen_q <= 1'b1;
      end

      if (start_issue) begin
        grant_b_q      <= pick_b;
        dir_write_q    <= win_write;
        access_address <= pick_b ? b_address : a_address;
        access_data_in <= pick_b ? b_data_in : a_data_in;
      end

      if (capture) begin
        if (grant_b_q) begin
          b_data_out <= access_data_out;
        end else begin
          a_data_out <= access_data_out;
        end
      end

      if (state_q == StDone) begin
        last_grant_b_q <= grant_b_q;
        mask_a_q       <= ~grant_b_q;
        mask_b_q       <= grant_b_q;
      end else begin
        mask_a_q <= 1'b0;
        mask_b_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int unsigned RefInt = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [24:0] a_address = '0, b_address = '0;
  logic [15:0] a_data_in = '0, b_data_in = '0;
  logic [15:0] a_data_out, b_data_out;
  logic        a_ack, b_ack;
  logic [24:0] access_address;
  logic [9:0]  access_num;
  logic [15:0] access_data_in;
  logic        write_request, read_request, enable_refresh;
  logic        write_flag, read_flag, idle, refresh_mode;
  logic [15:0] access_data_out;

  always #5 clk = ~clk;

  sdram_arbiter #(.REFRESH_INTERVAL(RefInt)) dut (
    .sdram_clock    (clk),
    .sdram_reset    (rst),
    .a_read         (a_read),
    .a_write        (a_write),
    .a_address      (a_address),
    .a_data_in      (a_data_in),
    .a_data_out     (a_data_out),
    .a_ack          (a_ack),
    .b_read         (b_read),
    .b_write        (b_write),
    .b_address      (b_address),
    .b_data_in      (b_data_in),
    .b_data_out     (b_data_out),
    .b_ack          (b_ack),
    .access_address (access_address),
    .access_num     (access_num),
    .access_data_in (access_data_in),
    .write_request  (write_request),
    .read_request   (read_request),
    .enable_refresh (enable_refresh),
    .write_flag     (write_flag),
    .read_flag      (read_flag),
    .idle           (idle),
    .refresh_mode   (refresh_mode),
    .access_data_out(access_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One controller transaction as seen by the controller model.
  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
  } rec_t;

  rec_t ctrl_q[$];

  // Per-port expectations (index 0 = A, 1 = B)
  logic [24:0] p_addr[2];
  logic [15:0] p_wdata[2];
  logic        p_wr[2];
  logic [15:0] dout_exp[2];
  int          acks[2];
  int          ack_log[$];

  bit hold_busy = 0;  // keep controller idle low to build up a due refresh
  bit force_rd  = 0;  // make the controller return 16'h5A5A

  // Behavioural SDRAM controller: accepts a request when idle, raises the
  // matching flag after a random latency for a random length, returns read
  // data during the flag, and performs refresh when triggered.
  int   cm_st = 0;
  int   cm_cnt = 0;
  rec_t cm_rec;

  initial begin
    idle = 1; write_flag = 0; read_flag = 0; refresh_mode = 0; access_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        idle = 1; write_flag = 0; read_flag = 0; refresh_mode = 0; cm_st = 0;
      end else begin
        case (cm_st)
          0: begin
            idle = !hold_busy;
            if (!hold_busy && enable_refresh) begin
              idle = 0; cm_cnt = $urandom_range(0, 2); cm_st = 4;
            end else if (!hold_busy && (write_request || read_request)) begin
              cm_rec.addr  = access_address;
              cm_rec.wdata = access_data_in;
              cm_rec.wr    = write_request;
              cm_rec.rdata = '0;
              idle = 0; cm_cnt = $urandom_range(0, 2); cm_st = 1;
            end
          end
          1: begin
            if (cm_cnt == 0) begin
              if (cm_rec.wr) begin
                write_flag = 1;
              end else begin
                cm_rec.rdata = force_rd ? 16'h5A5A : 16'($urandom);
                access_data_out = cm_rec.rdata;
                read_flag = 1;
              end
              cm_cnt = $urandom_range(1, 3); cm_st = 2;
            end else cm_cnt--;
          end
          2: begin
            if (cm_cnt == 0) begin
              write_flag = 0; read_flag = 0;
              access_data_out = 16'($urandom);
              ctrl_q.push_back(cm_rec);
              cm_st = 3;
            end else cm_cnt--;
          end
          3: begin idle = 1; cm_st = 0; end
          4: begin
            if (cm_cnt == 0) begin
              refresh_mode = 1; cm_cnt = $urandom_range(1, 3); cm_st = 5;
            end else cm_cnt--;
          end
          5: begin
            if (cm_cnt == 0) begin refresh_mode = 0; cm_st = 3; end
            else cm_cnt--;
          end
          default: cm_st = 0;
        endcase
      end
    end
  end

  // Monitor / scoreboard: every ack must match the oldest finished controller
  // transaction and the acked port's outstanding request.
  task automatic check_ack(input int p);
    rec_t        r;
    logic [15:0] dout;
    string       pn;
    pn   = (p == 0) ? "a" : "b";
    dout = (p == 0) ? a_data_out : b_data_out;
    acks[p]++;
    ack_log.push_back(p);
    if (ctrl_q.size() == 0) begin
      chk({pn, "_ack_without_txn"}, 1, 0);
    end else begin
      r = ctrl_q.pop_front();
      chk({pn, "_addr"}, 32'(r.addr), 32'(p_addr[p]));
      chk({pn, "_dir"}, 32'(r.wr), 32'(p_wr[p]));
      if (p_wr[p]) chk({pn, "_wdata"}, 32'(r.wdata), 32'(p_wdata[p]));
      else dout_exp[p] = r.rdata;
      chk({pn, "_data_out"}, 32'(dout), 32'(dout_exp[p]));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (a_ack && b_ack) chk("ack_overlap", 1, 0);
        if (a_ack) check_ack(0);
        if (b_ack) check_ack(1);
      end
    end
  end

  task automatic set_exp(input int p, input logic wr, input logic [24:0] ad,
                         input logic [15:0] d);
    p_wr[p] = wr; p_addr[p] = ad; p_wdata[p] = d;
  endtask

  task automatic drive_req(input int p);
    if (p == 0) begin
      a_write = p_wr[0]; a_read = !p_wr[0]; a_address = p_addr[0]; a_data_in = p_wdata[0];
    end else begin
      b_write = p_wr[1]; b_read = !p_wr[1]; b_address = p_addr[1]; b_data_in = p_wdata[1];
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) begin a_write = 0; a_read = 0; end
    else begin b_write = 0; b_read = 0; end
  endtask

  // Issue one request and hold it until its ack (bounded wait).
  task automatic do_op(input int p, input logic wr, input logic [24:0] ad,
                       input logic [15:0] d);
    bit got = 0;
    set_exp(p, wr, ad, d);
    @(negedge clk);
    drive_req(p);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? a_ack : b_ack) got = 1;
    end
    drop_req(p);
    if (!got) chk((p == 0) ? "a_ack_timeout" : "b_ack_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; hold_busy = 0; force_rd = 0;
    drop_req(0); drop_req(1);
    @(negedge clk);
    chk("rst_strobes", {write_request, read_request, enable_refresh, a_ack, b_ack}, 0);
    chk("rst_access_address", 32'(access_address), 0);
    chk("rst_access_data_in", 32'(access_data_in), 0);
    chk("rst_data_out", {a_data_out, b_data_out}, 0);
    chk("rst_access_num", 32'(access_num), 1);
    rst = 0;
    ctrl_q.delete();
    dout_exp[0] = '0; dout_exp[1] = '0;
  endtask

  task automatic port_proc(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_op(p, 1'($urandom_range(0, 1)), 25'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  a0, b0, start, last_pulse, pulses, cyc, lowcnt;
    bit  got, flag_seen, prev_en, en_seen, rm_prev, rm_fell;
    acks[0] = 0; acks[1] = 0;

    // Single A write
    apply_reset();
    a0 = acks[0]; b0 = acks[1];
    set_exp(0, 1, 25'h0001234, 16'hBEEF);
    @(negedge clk);
    drive_req(0);
    chk("wr_req_before_grant", 32'(write_request), 0);
    @(negedge clk);
    chk("wr_req_one_cycle_after", 32'(write_request), 1);
    got = 0; flag_seen = 0; lowcnt = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (write_flag) flag_seen = 1;
      if (!flag_seen && !write_request) lowcnt++;
      @(negedge clk);
      if (a_ack) got = 1;
    end
    drop_req(0);
    if (!got) chk("a_write_ack_timeout", 0, 1);
    chk("wr_req_held_until_flag", 32'(lowcnt), 0);
    repeat (5) @(negedge clk);
    chk("a_single_ack", 32'(acks[0] - a0), 1);
    chk("b_no_ack", 32'(acks[1] - b0), 0);

    // Port B read returning 16'h5A5A
    apply_reset();
    force_rd = 1;
    do_op(1, 0, 25'h1ABCDEF, 16'h0);
    force_rd = 0;
    chk("b_read_data", 32'(b_data_out), 32'h5A5A);
    chk("a_data_unchanged", 32'(a_data_out), 0);

    // Both ports requesting continuously: A, B, A, B
    apply_reset();
    set_exp(0, 1, 25'h0000AAA, 16'h1111);
    set_exp(1, 0, 25'h0000BBB, 16'h0);
    start = ack_log.size();
    @(negedge clk);
    drive_req(0); drive_req(1);
    for (int i = 0; i < 400 && ack_log.size() < start + 4; i++) @(negedge clk);
    drop_req(0); drop_req(1);
    if (ack_log.size() < start + 4) begin
      chk("rr_timeout", 32'(ack_log.size() - start), 4);
    end else begin
      for (int k = 0; k < 4; k++) chk("rr_order", 32'(ack_log[start + k]), 32'(k % 2));
    end
    repeat (10) @(negedge clk);

    // Refresh only: one-cycle pulses, RefInt+1 cycles apart
    apply_reset();
    last_pulse = 0; pulses = 0; prev_en = 0;
    for (cyc = 1; cyc <= 90; cyc++) begin
      @(negedge clk);
      if (enable_refresh) begin
        if (prev_en) chk("refresh_pulse_width", 2, 1);
        chk("refresh_spacing", 32'(cyc - last_pulse), RefInt + 1);
        last_pulse = cyc;
        pulses++;
      end
      prev_en = enable_refresh;
    end
    chk("refresh_pulse_count", 32'(pulses), 5);

    // Refresh due at the same time as an A request: refresh first
    apply_reset();
    hold_busy = 1;
    repeat (RefInt + 8) @(negedge clk);
    set_exp(0, 0, 25'h0C0FFEE, 16'h0);
    drive_req(0);
    repeat (2) @(negedge clk);
    hold_busy = 0;
    got = 0; en_seen = 0; rm_prev = 0; rm_fell = 0; flag_seen = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (enable_refresh) en_seen = 1;
      if (rm_prev && !refresh_mode) rm_fell = 1;
      rm_prev = refresh_mode;
      if (read_request && !flag_seen) begin
        flag_seen = 1;
        chk("refresh_before_grant", 32'(en_seen), 1);
        chk("grant_after_refresh_mode", 32'(rm_fell), 1);
      end
      if (a_ack) got = 1;
    end
    drop_req(0);
    if (!got) chk("refresh_then_a_timeout", 0, 1);

    // Reset while ACTIVE
    apply_reset();
    set_exp(0, 1, 25'h0055555, 16'hD00D);
    @(negedge clk);
    drive_req(0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (write_flag && !write_request) got = 1;
    end
    if (!got) chk("reach_active_timeout", 0, 1);
    rst = 1;
    drop_req(0);
    @(negedge clk);
    chk("midrst_strobes", {write_request, read_request, enable_refresh, a_ack, b_ack}, 0);
    chk("midrst_counter", 32'(dut.refresh_count_q), 0);
    chk("midrst_access_address", 32'(access_address), 0);
    rst = 0;
    ctrl_q.delete();
    dout_exp[0] = '0; dout_exp[1] = '0;
    a0 = acks[0];
    do_op(0, 0, 25'h0123456, 16'h0);
    chk("after_rst_ack", 32'(acks[0] - a0), 1);

    // Randomized traffic on both ports
    apply_reset();
    a0 = acks[0]; b0 = acks[1];
    fork
      port_proc(0, 12);
      port_proc(1, 12);
    join
    repeat (10) @(negedge clk);
    chk("rand_a_acks", 32'(acks[0] - a0), 12);
    chk("rand_b_acks", 32'(acks[1] - b0), 12);
    chk("rand_leftover_txns", 32'(ctrl_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and sequencer in front of the KFSDRAM request interface. It shares the single SDRAM controller between port A (CPU memory cycles from the RAM bus block) and port B (DMA / secondary bus master). It also schedules periodic auto-refresh independently of CPU bus idle states. It latches each granted transaction, drives the controller's request/flag handshake to completion, and returns read data with a one-cycle acknowledge.

## Interface
- REFRESH_INTERVAL, 780: clock cycles between refresh requests (~7.8 µs at 100 MHz).
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- a_read, a_write  in  1 each  port A level request; held until a_ack.
- a_address  in  25  port A word address.
- a_data_in  in  16  port A write data.
- a_data_out  out  16  port A read data; valid when a_ack=1.
- a_ack  out  1  one-cycle completion pulse for port A.
- b_read, b_write, b_address, b_data_in, b_data_out, b_ack: same as port A, for port B.
- access_address  out  25  to controller.
- access_num  out  10  burst length; constant 10'h001.
- access_data_in  out  16  to controller.
- write_request, read_request  out  1  to controller.
- enable_refresh  out  1  one-cycle refresh trigger to controller.
- write_flag, read_flag, idle, refresh_mode  in  1  controller status.
- access_data_out  in  16  controller read data.

## Operation
- States: IDLE, ISSUE, ACTIVE, DONE, REFRESH, REFRESH_WAIT.
- Refresh counter:
  - Increments every cycle and saturates at REFRESH_INTERVAL; refresh_due = (count == REFRESH_INTERVAL).
  - Cleared to 0 on the cycle REFRESH is entered.
- IDLE:
  - Priority 1: refresh_due and idle=1 → REFRESH.
  - Priority 2: otherwise, if idle=1 and any unmasked request is present → latch the winner's address, data and direction, then go to ISSUE.
  - Write beats read when a port asserts both.
  - Both ports requesting: the port not granted last wins (round-robin). last_grant resets to B, so A wins the first tie.
  - A request dropped before it is granted is ignored.
- ISSUE:
  - Drive access_address/access_data_in from the latch.
  - Hold the latched write_request or read_request high until the matching flag is seen high, then go to ACTIVE.
- ACTIVE:
  - Requests low.
  - While read_flag=1, capture access_data_out into the granted port's data_out register.
  - When the matching flag falls, go to DONE.
- DONE:
  - Pulse the granted port's ack for exactly one cycle.
  - Update last_grant, then return to IDLE.
  - The acked port is masked in IDLE for the one cycle following DONE, so a requester can drop its request the cycle after ack without being re-granted.
- Deasserting a request after grant does not abort the transaction; it completes and still acks.
- REFRESH: enable_refresh=1 for this single cycle, then go to REFRESH_WAIT.
- REFRESH_WAIT: wait until refresh_mode has been seen high and then idle=1, then go to IDLE.
- data_out registers hold their last captured value until the next read completion on that port. Writes leave them unchanged.

## Timing
- Reset values:
  - State IDLE, counter 0, last_grant=B, mask cleared.
  - All request, ack and enable_refresh outputs 0.
  - access_address, access_data_in and both data_out outputs 0.
  - access_num 10'h001.
- Reset mid-transaction returns to IDLE immediately without waiting for the controller. The controller is reset on the same reset.
- Grant latency: a request sampled in IDLE at edge t asserts read/write_request from edge t+1.
- Ack latency: the ack is asserted the cycle after the flag falls.
- Minimum request-to-ack time is controller latency plus 3 cycles.
- A pending refresh delays a request by at most one refresh sequence. A request already in progress delays refresh until DONE.
- Requests arriving during REFRESH/REFRESH_WAIT wait in IDLE. No requests are lost, since requests are level-held.
- All outputs are registered except access_num.

## Test plan
- Single port A write to 25'h0001234 with data 16'hBEEF:
  - write_request rises one cycle after a_write and stays high until write_flag.
  - Exactly one a_ack pulse; b_ack stays 0.
- Port B read where the model returns 16'h5A5A while read_flag is high → b_data_out=16'h5A5A on the b_ack cycle; a_data_out unchanged.
- A and B requesting continuously from reset → grants alternate A,B,A,B across 4 transactions. The acked port is never re-granted the cycle after its ack.
- REFRESH_INTERVAL=16, no requests → enable_refresh pulses one cycle wide, once per refresh sequence. The next pulse occurs no earlier than 16 cycles after REFRESH entry.
- refresh_due coincides with an A request in IDLE → refresh goes first. A is granted after refresh_mode falls and idle=1, and a_ack follows.
- Assert reset while in ACTIVE → the next cycle shows IDLE, all requests/acks 0 and counter 0. A fresh request afterwards completes normally.
